// File: rtl/tape_rec_if.sv
// tape_rec_if: tape RAM write port driven by the cassette recorder.
interface tape_rec_if;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    modport master(output addr, data, we);
    modport slave(input addr, data, we);
endinterface

// File: rtl/tape_rec.sv
// tape_rec: measures cassette-out periods, decodes framed bytes (start 0, 8 bits MSB first, 2 stop 1s)
// and writes them into the tape RAM through the write-port interface.
module tape_rec #(
    parameter int CNT_W      = 8,
    parameter int MIN_PERIOD = 4,
    parameter int BIT_THRESH = 16,
    parameter int MAX_PERIOD = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_tape,
    input  logic        rec,
    input  logic        cass_in,
    tape_rec_if.master  ram,
    output logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        full
);
    typedef enum logic [2:0] {IDLE, HUNT, DATA, STOP1, STOP2, WRITE} state_t;
    localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] THR = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_PERIOD);
    state_t r_state, w_next;
    logic r_s1, r_s2, r_prev, r_we, r_done, r_err, r_full;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0] r_sr, r_data;
    logic [2:0] r_idx;
    logic [15:0] r_length, r_addr;
    logic w_rise, w_bv, w_bit, w_tmo, w_abort, w_arm, w_shift, w_bad, w_write, w_stop;
    assign w_rise  = ce_tape && r_s2 && !r_prev;
    // a saturated count never yields a bit, so the first edge after arming is dropped
    assign w_bv    = w_rise && r_cnt >= MIN && r_cnt < MAX;
    assign w_bit   = r_cnt < THR;
    assign w_tmo   = ce_tape && !w_rise && r_cnt == MAX - 1'b1;
    assign w_abort = r_state inside {HUNT, DATA, STOP1, STOP2} && (!rec || (w_tmo && r_length != 16'd0));
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next  = r_state;
        w_arm   = 1'b0;
        w_shift = 1'b0;
        w_bad   = 1'b0;
        w_write = 1'b0;
        w_stop  = 1'b0;
        if (r_state == IDLE) begin
            w_arm  = rec;
            w_next = rec ? HUNT : IDLE;
        end else if (w_abort) begin
            w_stop = 1'b1;
            w_next = IDLE;
        end else if (w_tmo) begin
            w_next = HUNT;
        end else begin
            case (r_state)
                HUNT:  w_next = (w_bv && !w_bit) ? DATA : HUNT;
                DATA: begin
                    w_shift = w_bv;
                    w_next  = (w_bv && r_idx == 3'd7) ? STOP1 : DATA;
                end
                STOP1: begin
                    w_bad  = w_bv && !w_bit;
                    w_next = !w_bv ? STOP1 : w_bit ? STOP2 : HUNT;
                end
                STOP2: begin
                    w_bad  = w_bv && !w_bit;
                    w_next = !w_bv ? STOP2 : w_bit ? WRITE : HUNT;
                end
                WRITE: begin
                    w_write = 1'b1;
                    w_next  = HUNT;
                end
                default: w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            {r_s1, r_s2, r_prev, r_we, r_done, r_err, r_full} <= '0;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_data   <= '0;
            r_idx    <= '0;
            r_length <= '0;
            r_addr   <= '0;
        end else begin
            r_s1   <= cass_in;
            r_s2   <= r_s1;
            r_done <= w_stop;
            r_we   <= w_write && !r_full;
            if (ce_tape) r_prev <= r_s2;
            if (w_arm) r_cnt <= MAX;
            else if (ce_tape) r_cnt <= w_rise ? CNT_W'(1) : (r_cnt == MAX ? MAX : r_cnt + 1'b1);
            if (r_state == HUNT) r_idx <= '0;
            else if (w_shift) r_idx <= r_idx + 1'b1;
            if (w_shift) r_sr <= {r_sr[6:0], w_bit};
            if (w_bad) r_err <= 1'b1;
            if (w_arm) begin
                r_length <= '0;
                r_addr   <= '0;
                r_err    <= 1'b0;
                r_full   <= 1'b0;
            end
            // the last RAM slot is written, then length sticks at 0xFFFF instead of wrapping
            if (w_write && !r_full) begin
                r_addr <= r_length;
                r_data <= r_sr;
                if (r_length == 16'hFFFF) r_full <= 1'b1;
                else r_length <= r_length + 1'b1;
            end
        end
    assign ram.addr = r_addr;
    assign ram.data = r_data;
    assign ram.we   = r_we;
    assign length   = r_length;
    assign busy     = r_state != IDLE;
    assign done     = r_done;
    assign err      = r_err;
    assign full     = r_full;
endmodule

// File: tb/tb_tape_rec.sv
// tb_tape_rec: directed cassette waveforms with hand-computed bytes, lengths and flags.
module tb_tape_rec;
    logic clk = 0, reset_n = 0, ce_tape = 0, rec = 0, cass_in = 0;
    logic [15:0] length;
    logic busy, done, err, full;
    int n_chk = 0, n_fail = 0, n_we = 0, n_done = 0;
    tape_rec_if ram_if();
    tape_rec dut (
        .clk(clk), .reset_n(reset_n), .ce_tape(ce_tape), .rec(rec), .cass_in(cass_in),
        .ram(ram_if), .length(length), .busy(busy), .done(done), .err(err), .full(full)
    );
    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        ce_tape = ~ce_tape;
    end
    always @(negedge clk) begin
        if (ram_if.we) n_we++;
        if (done) n_done++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        do @(posedge clk); while (!ce_tape);
        #2;
    endtask
    task automatic per(input int n);
        cass_in = 1;
        repeat (n / 2) tick();
        cass_in = 0;
        repeat (n - n / 2) tick();
    endtask
    task automatic leader(input int n);
        repeat (n) per(8);
    endtask
    task automatic send_byte(input logic [7:0] b, input int stop2, input bit glitch);
        per(24);
        for (int i = 7; i >= 0; i--) begin
            per(b[i] ? 8 : 24);
            if (glitch) per(2);
        end
        per(8);
        per(stop2);
    endtask
    task automatic wait_done(input string tag);
        logic hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = done;
        end
        rec = 0;
        check(tag, hit, 1);
        repeat (4) @(negedge clk);
    endtask
    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_len", length, 0);
        check("rst_addr", ram_if.addr, 0);
        check("rst_data", ram_if.data, 0);
        check("rst_we", ram_if.we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        @(negedge clk);
        reset_n = 1;
        repeat (4) @(negedge clk);
        rec = 1;
        leader(20);
        send_byte(8'hA5, 8, 0);
        cass_in = 1;
        repeat (50) tick();
        check("a5_no_early_done", n_done, 0);
        check("a5_busy", busy, 1);
        wait_done("a5_done");
        check("a5_we", n_we, 1);
        check("a5_addr", ram_if.addr, 0);
        check("a5_data", ram_if.data, 8'hA5);
        check("a5_len", length, 1);
        check("a5_err", err, 0);
        check("a5_idle", busy, 0);
        check("a5_done_cnt", n_done, 1);
        cass_in = 0;
        rec = 1;
        leader(10);
        send_byte(8'h3C, 8, 1);
        cass_in = 1;
        wait_done("gl_done");
        check("gl_we", n_we, 2);
        check("gl_addr", ram_if.addr, 0);
        check("gl_data", ram_if.data, 8'h3C);
        check("gl_len", length, 1);
        check("gl_err", err, 0);
        cass_in = 0;
        rec = 1;
        leader(10);
        send_byte(8'h55, 24, 0);
        leader(5);
        check("fe_err", err, 1);
        check("fe_no_we", n_we, 2);
        check("fe_len0", length, 0);
        send_byte(8'h12, 8, 0);
        leader(3);
        check("fe_we", n_we, 3);
        check("fe_addr", ram_if.addr, 0);
        check("fe_data", ram_if.data, 8'h12);
        check("fe_len", length, 1);
        per(24);
        per(24);
        per(8);
        per(24);
        per(8);
        cass_in = 1;
        repeat (3) tick();
        rec = 0;
        wait_done("drop_done");
        check("drop_we", n_we, 3);
        check("drop_len", length, 1);
        check("drop_busy", busy, 0);
        check("drop_err", err, 1);
        check("drop_data", ram_if.data, 8'h12);
        check("drop_done_cnt", n_done, 3);
        cass_in = 0;
        rec = 1;
        leader(5);
        send_byte(8'h11, 8, 0);
        send_byte(8'h22, 8, 0);
        send_byte(8'h33, 8, 0);
        per(24);
        per(8);
        per(24);
        cass_in = 1;
        repeat (2) tick();
        check("mid_len", length, 3);
        check("mid_data", ram_if.data, 8'h33);
        check("mid_busy", busy, 1);
        #1 reset_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_len", length, 0);
        check("mid_rst_addr", ram_if.addr, 0);
        check("mid_rst_data", ram_if.data, 0);
        check("mid_rst_err", err, 0);
        rec = 0;
        cass_in = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (4) @(negedge clk);
        check("mid_idle", busy, 0);
        n_we = 0;
        rec = 1;
        leader(3);
        force dut.r_length = 16'hFFFF;
        #1 release dut.r_length;
        check("full_pre", length, 16'hFFFF);
        send_byte(8'h5A, 8, 0);
        send_byte(8'hC3, 8, 0);
        leader(2);
        check("full_we", n_we, 1);
        check("full_addr", ram_if.addr, 16'hFFFF);
        check("full_data", ram_if.data, 8'h5A);
        check("full_flag", full, 1);
        check("full_len", length, 16'hFFFF);
        wait_done("full_done");
        check("full_sticky", full, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
